// File: rtl/uart_rx_cmd_ctrl_if.sv
// -----------------------------------------------------------------------------
// uart_rx_cmd_ctrl_if
//
// Purpose : command-side bundle between the UART packet controller and the
//           downstream consumer. Carries the valid/ready command handshake,
//           the latched command header and the payload-buffer read port.
//
// Parameters:
//   DATA_W   - byte width (matches UART_DATA_WIDTH of the controller)
//   MAX_LEN  - payload buffer depth, sets the read-address width
//
// Signals:
//   Cmd_Valid   controller -> consumer  command available
//   Cmd_Ready   consumer  -> controller  command accepted
//   Cmd_Opcode  controller -> consumer  command opcode
//   Cmd_Len     controller -> consumer  payload length
//   Pld_Raddr   consumer  -> controller  payload read address
//   Pld_Rdata   controller -> consumer  payload byte (combinational read)
//
// Modports: master = packet controller, slave = downstream consumer.
// -----------------------------------------------------------------------------
interface uart_rx_cmd_ctrl_if #(
  parameter int DATA_W  = 8,
  parameter int MAX_LEN = 16
);
  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  logic              Cmd_Valid;
  logic              Cmd_Ready;
  logic [DATA_W-1:0] Cmd_Opcode;
  logic [DATA_W-1:0] Cmd_Len;
  logic [IDX_W-1:0]  Pld_Raddr;
  logic [DATA_W-1:0] Pld_Rdata;

  modport master (
    output Cmd_Valid,
    output Cmd_Opcode,
    output Cmd_Len,
    output Pld_Rdata,
    input  Cmd_Ready,
    input  Pld_Raddr
  );

  modport slave (
    input  Cmd_Valid,
    input  Cmd_Opcode,
    input  Cmd_Len,
    input  Pld_Rdata,
    output Cmd_Ready,
    output Pld_Raddr
  );
endinterface

// File: rtl/uart_rx_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_cmd_ctrl
//
// Purpose : packet controller sitting directly behind the UART receiver.
//           Frames received bytes into command packets
//             SYNC, CMD, LEN, payload[LEN], CHK
//           where CHK makes (CMD + LEN + payload) mod 256 equal zero.
//           Good commands are buffered and presented downstream over a
//           valid/ready handshake; a command whose opcode is CFG_OPCODE
//           instead reprograms the receiver's baud divisor from its 4-byte
//           little-endian payload.
//
// Optional feature (compile-time macro UART_RX_CMD_TIMEOUT_EN):
//   defined   - inter-byte timeout counter; a partial frame idle for
//               TIMEOUT_CYCLES clocks is abandoned with o_Err_Timeout.
//   undefined - no counter, o_Err_Timeout is tied low and a partial frame
//               waits indefinitely for its next byte.
//
// Ports:
//   i_Clock             in   system clock, all logic on its rising edge
//   i_Reset             in   synchronous active-high reset
//   i_Rx_DV             in   one-cycle byte-valid pulse from the receiver
//   i_Rx_Byte           in   received byte, qualified by i_Rx_DV
//   o_uart_config_data  out  baud divisor driven to the receiver
//   cmd_bus             if   command handshake + payload read port (master)
//   o_Err_Chk           out  one-cycle pulse: checksum mismatch
//   o_Err_Len           out  one-cycle pulse: LEN too large / bad config LEN
//   o_Err_Timeout       out  one-cycle pulse: inter-byte timeout
//   o_Overrun           out  one-cycle pulse: byte dropped while holding
// -----------------------------------------------------------------------------
module uart_rx_cmd_ctrl #(
  parameter int                             UART_DATA_WIDTH   = 8,
  parameter int                             CONFIG_DATA_WIDTH = 32,
  parameter int                             MAX_LEN           = 16,
  parameter logic [UART_DATA_WIDTH-1:0]     SYNC_BYTE         = 8'hA5,
  parameter logic [UART_DATA_WIDTH-1:0]     CFG_OPCODE        = 8'hC0,
  parameter logic [CONFIG_DATA_WIDTH-1:0]   DEFAULT_DIV       = 32'd437,
  parameter logic [31:0]                    TIMEOUT_CYCLES    = 32'd100000
) (
  input  logic                         i_Clock,
  input  logic                         i_Reset,
  input  logic                         i_Rx_DV,
  input  logic [UART_DATA_WIDTH-1:0]   i_Rx_Byte,
  output logic [CONFIG_DATA_WIDTH-1:0] o_uart_config_data,
  uart_rx_cmd_ctrl_if.master           cmd_bus,
  output logic                         o_Err_Chk,
  output logic                         o_Err_Len,
  output logic                         o_Err_Timeout,
  output logic                         o_Overrun
);

  localparam int BW    = UART_DATA_WIDTH;
  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [BW-1:0]    ZERO_B    = {BW{1'b0}};
  localparam logic [BW-1:0]    ONE_B     = BW'(1);
  localparam logic [BW-1:0]    MAX_LEN_B = BW'(MAX_LEN);
  // The divisor word is carried as exactly four payload bytes.
  localparam logic [BW-1:0]    CFG_LEN_B = BW'(4);
  localparam logic [IDX_W-1:0] IDX_ZERO  = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

  localparam logic [2:0] S_SYNC = 3'd0;
  localparam logic [2:0] S_CMD  = 3'd1;
  localparam logic [2:0] S_LEN  = 3'd2;
  localparam logic [2:0] S_PLD  = 3'd3;
  localparam logic [2:0] S_CHK  = 3'd4;
  localparam logic [2:0] S_HOLD = 3'd5;

  logic [2:0]                   state_r;
  logic [BW-1:0]                opcode_r;
  logic [BW-1:0]                len_r;
  logic [BW-1:0]                sum_r;
  logic [IDX_W-1:0]             idx_r;
  logic                         cmd_valid_r;
  logic                         err_chk_r;
  logic                         err_len_r;
  logic                         err_tmo_r;
  logic                         overrun_r;
  logic [CONFIG_DATA_WIDTH-1:0] div_r;
  logic [BW-1:0]                buf_r [0:MAX_LEN-1];

  logic [BW-1:0]                sum_next_s;
  logic                         last_pld_s;
  logic                         len_bad_s;
  logic [4*BW-1:0]              cfg_word_s;
  logic                         tmo_hit_s;

  // Running checksum including the byte currently on the bus (wraps mod 256).
  assign sum_next_s = sum_r + i_Rx_Byte;

  // Current payload byte is the last one when idx has reached len-1.
  assign last_pld_s = (BW'(idx_r) == (len_r - ONE_B));

  // LEN rejected if it overflows the buffer, or a config command is not 4 bytes.
  assign len_bad_s = (i_Rx_Byte > MAX_LEN_B) ||
                     ((opcode_r == CFG_OPCODE) && (i_Rx_Byte != CFG_LEN_B));

  // Divisor assembled little-endian from the first four payload bytes.
  assign cfg_word_s = {buf_r[3], buf_r[2], buf_r[1], buf_r[0]};

`ifdef UART_RX_CMD_TIMEOUT_EN
  logic [31:0] tmo_cnt_r;
  logic        tmo_active_s;

  // Only a partially received frame can time out.
  assign tmo_active_s = (state_r == S_CMD) || (state_r == S_LEN) ||
                        (state_r == S_PLD) || (state_r == S_CHK);

  // A byte arriving in the expiry cycle wins over the timeout.
  assign tmo_hit_s = tmo_active_s && !i_Rx_DV &&
                     (tmo_cnt_r == (TIMEOUT_CYCLES - 32'd1));

  // Inter-byte idle counter; every byte (and hence every state entry) restarts it.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      tmo_cnt_r <= 32'd0;
    end else if (!tmo_active_s || i_Rx_DV || tmo_hit_s) begin
      tmo_cnt_r <= 32'd0;
    end else begin
      tmo_cnt_r <= tmo_cnt_r + 32'd1;
    end
  end
`else
  logic unused_timeout_cfg_s;

  assign unused_timeout_cfg_s = ^TIMEOUT_CYCLES;
  assign tmo_hit_s            = 1'b0;
`endif

  // Frame parser: state, header fields, checksum, payload index, divisor,
  // command handshake and one-cycle error pulses.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_r     <= S_SYNC;
      opcode_r    <= ZERO_B;
      len_r       <= ZERO_B;
      sum_r       <= ZERO_B;
      idx_r       <= IDX_ZERO;
      cmd_valid_r <= 1'b0;
      err_chk_r   <= 1'b0;
      err_len_r   <= 1'b0;
      err_tmo_r   <= 1'b0;
      overrun_r   <= 1'b0;
      div_r       <= DEFAULT_DIV;
    end else begin
      err_chk_r <= 1'b0;
      err_len_r <= 1'b0;
      err_tmo_r <= 1'b0;
      overrun_r <= 1'b0;

      if (tmo_hit_s) begin
        err_tmo_r <= 1'b1;
        state_r   <= S_SYNC;
      end else begin
        case (state_r)
          S_SYNC: begin
            // Anything other than the marker is line noise and is dropped.
            if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) begin
              sum_r   <= ZERO_B;
              state_r <= S_CMD;
            end
          end

          S_CMD: begin
            if (i_Rx_DV) begin
              opcode_r <= i_Rx_Byte;
              sum_r    <= i_Rx_Byte;
              state_r  <= S_LEN;
            end
          end

          S_LEN: begin
            if (i_Rx_DV) begin
              len_r <= i_Rx_Byte;
              sum_r <= sum_next_s;
              if (len_bad_s) begin
                err_len_r <= 1'b1;
                state_r   <= S_SYNC;
              end else if (i_Rx_Byte == ZERO_B) begin
                state_r <= S_CHK;
              end else begin
                idx_r   <= IDX_ZERO;
                state_r <= S_PLD;
              end
            end
          end

          S_PLD: begin
            // SYNC_BYTE here is ordinary data; framing is by length only.
            if (i_Rx_DV) begin
              sum_r <= sum_next_s;
              if (last_pld_s) begin
                state_r <= S_CHK;
              end else begin
                idx_r <= idx_r + IDX_ONE;
              end
            end
          end

          S_CHK: begin
            if (i_Rx_DV) begin
              if (sum_next_s != ZERO_B) begin
                err_chk_r <= 1'b1;
                state_r   <= S_SYNC;
              end else if (opcode_r == CFG_OPCODE) begin
                div_r   <= CONFIG_DATA_WIDTH'(cfg_word_s);
                state_r <= S_SYNC;
              end else begin
                cmd_valid_r <= 1'b1;
                state_r     <= S_HOLD;
              end
            end
          end

          S_HOLD: begin
            // Buffer is frozen while the command is offered; new bytes are lost.
            if (i_Rx_DV) begin
              overrun_r <= 1'b1;
            end
            if (cmd_valid_r && cmd_bus.Cmd_Ready) begin
              cmd_valid_r <= 1'b0;
              state_r     <= S_SYNC;
            end
          end

          default: begin
            cmd_valid_r <= 1'b0;
            state_r     <= S_SYNC;
          end
        endcase
      end
    end
  end

  // Payload store; contents are only meaningful up to the latched length.
  always_ff @(posedge i_Clock) begin
    if (i_Rx_DV && (state_r == S_PLD)) begin
      buf_r[idx_r] <= i_Rx_Byte;
    end
  end

  assign cmd_bus.Cmd_Valid  = cmd_valid_r;
  assign cmd_bus.Cmd_Opcode = opcode_r;
  assign cmd_bus.Cmd_Len    = len_r;
  assign cmd_bus.Pld_Rdata  = buf_r[cmd_bus.Pld_Raddr];

  assign o_uart_config_data = div_r;
  assign o_Err_Chk          = err_chk_r;
  assign o_Err_Len          = err_len_r;
  assign o_Err_Timeout      = err_tmo_r;
  assign o_Overrun          = overrun_r;

endmodule

// File: tb/tb_uart_rx_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_cmd_ctrl
//
// Self-checking bench for uart_rx_cmd_ctrl. Each scenario task drives byte
// streams, pushes the commands it expects onto a scoreboard queue and pops /
// compares them when the controller presents a command.
// -----------------------------------------------------------------------------
module tb_uart_rx_cmd_ctrl;

  localparam int          MAX_LEN  = 16;
  localparam logic [31:0] TMO      = 32'd100000;

  typedef struct packed {
    logic [7:0]       op;
    logic [7:0]       len;
    logic [15:0][7:0] pld;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        rx_dv;
  logic [7:0]  rx_byte;
  logic [31:0] cfg_data;
  logic        err_chk;
  logic        err_len;
  logic        err_tmo;
  logic        overrun;

  logic [7:0]  tx_q [$];
  exp_t        exp_q [$];

  int vectors     = 0;
  int miscompares = 0;
  int chk_n = 0;
  int len_n = 0;
  int tmo_n = 0;
  int ovr_n = 0;
  int vld_n = 0;

  uart_rx_cmd_ctrl_if #(.DATA_W(8), .MAX_LEN(MAX_LEN)) cmd_if ();

  uart_rx_cmd_ctrl #(.MAX_LEN(MAX_LEN)) dut (
    .i_Clock            (clk),
    .i_Reset            (rst),
    .i_Rx_DV            (rx_dv),
    .i_Rx_Byte          (rx_byte),
    .o_uart_config_data (cfg_data),
    .cmd_bus            (cmd_if.master),
    .o_Err_Chk          (err_chk),
    .o_Err_Len          (err_len),
    .o_Err_Timeout      (err_tmo),
    .o_Overrun          (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse and valid-cycle counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (err_chk === 1'b1) chk_n++;
    if (err_len === 1'b1) len_n++;
    if (err_tmo === 1'b1) tmo_n++;
    if (overrun === 1'b1) ovr_n++;
    if (cmd_if.Cmd_Valid === 1'b1) vld_n++;
  end

  // Sends tx_q, one byte-valid pulse per byte with idle gaps; returns on the
  // falling edge right after the last byte was sampled.
  task automatic send_q();
    foreach (tx_q[i]) begin
      repeat (2) @(negedge clk);
      rx_dv   = 1'b1;
      rx_byte = tx_q[i];
      @(negedge clk);
      rx_dv   = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx_dv = 1'b0;
    rx_byte = 8'h00;
    cmd_if.Cmd_Ready = 1'b0;
    cmd_if.Pld_Raddr = 4'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (cfg_data !== 32'd437) begin
      miscompares++; $display("FAIL reset_div: got %0d want 437", cfg_data);
    end
    vectors++;
    if (cmd_if.Cmd_Valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_valid: got %b want 0", cmd_if.Cmd_Valid);
    end
    vectors++;
    if ({cmd_if.Cmd_Opcode, cmd_if.Cmd_Len} !== 16'h0000) begin
      miscompares++; $display("FAIL reset_hdr: got %h want 0000", {cmd_if.Cmd_Opcode, cmd_if.Cmd_Len});
    end
    vectors++;
    if ({err_chk, err_len, err_tmo, overrun} !== 4'b0000) begin
      miscompares++; $display("FAIL reset_err: got %b want 0000", {err_chk, err_len, err_tmo, overrun});
    end
  endtask

  task automatic test_basic_cmd();
    exp_t e;
    int   v0;
    e = '0; e.op = 8'h10; e.len = 8'd2; e.pld[0] = 8'h11; e.pld[1] = 8'h22;
    exp_q.push_back(e);
    cmd_if.Cmd_Ready = 1'b1;
    v0 = vld_n;
    tx_q = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'hBB};
    send_q();
    vectors++;
    if (cmd_if.Cmd_Valid !== 1'b1) begin
      miscompares++; $display("FAIL basic_valid: got %b want 1", cmd_if.Cmd_Valid);
    end
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++; $display("FAIL basic_sb: got empty scoreboard want entry");
    end else begin
      e = exp_q.pop_front();
      vectors++;
      if (cmd_if.Cmd_Opcode !== e.op) begin
        miscompares++; $display("FAIL basic_op: got %h want %h", cmd_if.Cmd_Opcode, e.op);
      end
      vectors++;
      if (cmd_if.Cmd_Len !== e.len) begin
        miscompares++; $display("FAIL basic_len: got %0d want %0d", cmd_if.Cmd_Len, e.len);
      end
      for (int i = 0; i < int'(e.len); i++) begin
        cmd_if.Pld_Raddr = 4'(i); #1;
        vectors++;
        if (cmd_if.Pld_Rdata !== e.pld[i]) begin
          miscompares++; $display("FAIL basic_pld[%0d]: got %h want %h", i, cmd_if.Pld_Rdata, e.pld[i]);
        end
      end
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (vld_n - v0 != 1) begin
      miscompares++; $display("FAIL basic_valid_cycles: got %0d want 1", vld_n - v0);
    end
  endtask

  task automatic test_config();
    int v0;
    v0 = vld_n;
    tx_q = '{8'hA5, 8'hC0, 8'h04, 8'hD9, 8'h00, 8'h00, 8'h00, 8'h63};
    send_q();
    vectors++;
    if (cfg_data !== 32'd217) begin
      miscompares++; $display("FAIL cfg_div: got %0d want 217", cfg_data);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (vld_n != v0) begin
      miscompares++; $display("FAIL cfg_no_cmd: got %0d valid cycles want 0", vld_n - v0);
    end
  endtask

  task automatic test_bad_checksum();
    exp_t e;
    int   c0;
    int   v0;
    c0 = chk_n; v0 = vld_n;
    tx_q = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'hBC};
    send_q();
    repeat (3) @(negedge clk);
    vectors++;
    if (chk_n - c0 != 1) begin
      miscompares++; $display("FAIL chk_pulse: got %0d pulses want 1", chk_n - c0);
    end
    vectors++;
    if (vld_n != v0) begin
      miscompares++; $display("FAIL chk_no_cmd: got %0d valid cycles want 0", vld_n - v0);
    end
    e = '0; e.op = 8'h20; e.len = 8'd1; e.pld[0] = 8'h7E;
    exp_q.push_back(e);
    tx_q = '{8'hA5, 8'h20, 8'h01, 8'h7E, 8'h61};
    send_q();
    vectors++;
    if (cmd_if.Cmd_Valid !== 1'b1) begin
      miscompares++; $display("FAIL chk_next_valid: got %b want 1", cmd_if.Cmd_Valid);
    end
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++; $display("FAIL chk_next_sb: got empty scoreboard want entry");
    end else begin
      e = exp_q.pop_front();
      vectors++;
      if ({cmd_if.Cmd_Opcode, cmd_if.Cmd_Len} !== {e.op, e.len}) begin
        miscompares++; $display("FAIL chk_next_hdr: got %h want %h", {cmd_if.Cmd_Opcode, cmd_if.Cmd_Len}, {e.op, e.len});
      end
      cmd_if.Pld_Raddr = 4'd0; #1;
      vectors++;
      if (cmd_if.Pld_Rdata !== e.pld[0]) begin
        miscompares++; $display("FAIL chk_next_pld: got %h want %h", cmd_if.Pld_Rdata, e.pld[0]);
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_bad_len();
    exp_t e;
    int   l0;
    int   c0;
    int   v0;
    l0 = len_n; c0 = chk_n; v0 = vld_n;
    tx_q = '{8'hA5, 8'h10, 8'h11};
    send_q();
    repeat (2) @(negedge clk);
    vectors++;
    if (len_n - l0 != 1) begin
      miscompares++; $display("FAIL len_big_pulse: got %0d pulses want 1", len_n - l0);
    end
    // Would be a complete frame if the parser had not dropped back to SYNC.
    tx_q = '{8'h10, 8'h00, 8'hF0};
    send_q();
    repeat (2) @(negedge clk);
    vectors++;
    if ((vld_n != v0) || (chk_n != c0) || (len_n - l0 != 1)) begin
      miscompares++; $display("FAIL len_ignore: got valid=%0d chk=%0d len=%0d want 0 0 1", vld_n - v0, chk_n - c0, len_n - l0);
    end
    tx_q = '{8'hA5, 8'hC0, 8'h02};
    send_q();
    repeat (2) @(negedge clk);
    vectors++;
    if (len_n - l0 != 2) begin
      miscompares++; $display("FAIL len_cfg_pulse: got %0d pulses want 2", len_n - l0);
    end
    e = '0; e.op = 8'h33; e.len = 8'd0;
    exp_q.push_back(e);
    tx_q = '{8'hA5, 8'h33, 8'h00, 8'hCD};
    send_q();
    vectors++;
    if (cmd_if.Cmd_Valid !== 1'b1) begin
      miscompares++; $display("FAIL len0_valid: got %b want 1", cmd_if.Cmd_Valid);
    end
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++; $display("FAIL len0_sb: got empty scoreboard want entry");
    end else begin
      e = exp_q.pop_front();
      vectors++;
      if ({cmd_if.Cmd_Opcode, cmd_if.Cmd_Len} !== {e.op, e.len}) begin
        miscompares++; $display("FAIL len0_hdr: got %h want %h", {cmd_if.Cmd_Opcode, cmd_if.Cmd_Len}, {e.op, e.len});
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_overrun();
    exp_t e;
    int   o0;
    e = '0; e.op = 8'h42; e.len = 8'd3; e.pld[0] = 8'hA5; e.pld[1] = 8'h5A; e.pld[2] = 8'h01;
    exp_q.push_back(e);
    cmd_if.Cmd_Ready = 1'b0;
    o0 = ovr_n;
    tx_q = '{8'hA5, 8'h42, 8'h03, 8'hA5, 8'h5A, 8'h01, 8'hBB};
    send_q();
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++; $display("FAIL ovr_sb: got empty scoreboard want entry");
    end else begin
      e = exp_q.pop_front();
    end
    tx_q = '{8'h55};
    send_q();
    repeat (2) @(negedge clk);
    vectors++;
    if (ovr_n - o0 != 1) begin
      miscompares++; $display("FAIL ovr_pulse: got %0d pulses want 1", ovr_n - o0);
    end
    vectors++;
    if (cmd_if.Cmd_Valid !== 1'b1) begin
      miscompares++; $display("FAIL ovr_hold_valid: got %b want 1", cmd_if.Cmd_Valid);
    end
    vectors++;
    if ({cmd_if.Cmd_Opcode, cmd_if.Cmd_Len} !== {e.op, e.len}) begin
      miscompares++; $display("FAIL ovr_hdr: got %h want %h", {cmd_if.Cmd_Opcode, cmd_if.Cmd_Len}, {e.op, e.len});
    end
    for (int i = 0; i < 3; i++) begin
      cmd_if.Pld_Raddr = 4'(i); #1;
      vectors++;
      if (cmd_if.Pld_Rdata !== e.pld[i]) begin
        miscompares++; $display("FAIL ovr_pld[%0d]: got %h want %h", i, cmd_if.Pld_Rdata, e.pld[i]);
      end
    end
    @(negedge clk);
    cmd_if.Cmd_Ready = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (cmd_if.Cmd_Valid !== 1'b0) begin
      miscompares++; $display("FAIL ovr_release: got %b want 0", cmd_if.Cmd_Valid);
    end
  endtask

  task automatic test_max_len();
    exp_t       e;
    logic [7:0] sum;
    cmd_if.Cmd_Ready = 1'b0;
    e = '0; e.op = 8'h5C; e.len = 8'd16;
    sum = e.op + e.len;
    tx_q = '{8'hA5, e.op, e.len};
    for (int i = 0; i < 16; i++) begin
      e.pld[i] = 8'(i * 37 + 5);
      sum = sum + e.pld[i];
      tx_q.push_back(e.pld[i]);
    end
    tx_q.push_back(8'h00 - sum);
    exp_q.push_back(e);
    send_q();
    vectors++;
    if (cmd_if.Cmd_Valid !== 1'b1) begin
      miscompares++; $display("FAIL max_valid: got %b want 1", cmd_if.Cmd_Valid);
    end
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++; $display("FAIL max_sb: got empty scoreboard want entry");
    end else begin
      e = exp_q.pop_front();
      vectors++;
      if ({cmd_if.Cmd_Opcode, cmd_if.Cmd_Len} !== {e.op, e.len}) begin
        miscompares++; $display("FAIL max_hdr: got %h want %h", {cmd_if.Cmd_Opcode, cmd_if.Cmd_Len}, {e.op, e.len});
      end
      for (int i = 0; i < 16; i++) begin
        cmd_if.Pld_Raddr = 4'(i); #1;
        vectors++;
        if (cmd_if.Pld_Rdata !== e.pld[i]) begin
          miscompares++; $display("FAIL max_pld[%0d]: got %h want %h", i, cmd_if.Pld_Rdata, e.pld[i]);
        end
      end
    end
    @(negedge clk);
    cmd_if.Cmd_Ready = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    exp_t e;
    int   v0;
    tx_q = '{8'hA5, 8'hC0, 8'h04, 8'h01, 8'h02, 8'h00, 8'h00, 8'h39};
    send_q();
    vectors++;
    if (cfg_data !== 32'd513) begin
      miscompares++; $display("FAIL mid_cfg_div: got %0d want 513", cfg_data);
    end
    tx_q = '{8'hA5, 8'h10, 8'h04, 8'h11};
    send_q();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (cfg_data !== 32'd437) begin
      miscompares++; $display("FAIL mid_rst_div: got %0d want 437", cfg_data);
    end
    vectors++;
    if (cmd_if.Cmd_Valid !== 1'b0) begin
      miscompares++; $display("FAIL mid_rst_valid: got %b want 0", cmd_if.Cmd_Valid);
    end
    v0 = vld_n;
    // Tail of the discarded frame must not complete anything.
    tx_q = '{8'h22, 8'h33, 8'h44};
    send_q();
    repeat (2) @(negedge clk);
    vectors++;
    if (vld_n != v0) begin
      miscompares++; $display("FAIL mid_tail: got %0d valid cycles want 0", vld_n - v0);
    end
    e = '0; e.op = 8'h10; e.len = 8'd2; e.pld[0] = 8'h11; e.pld[1] = 8'h22;
    exp_q.push_back(e);
    tx_q = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'hBB};
    send_q();
    vectors++;
    if (exp_q.size() == 0 || cmd_if.Cmd_Valid !== 1'b1) begin
      miscompares++; $display("FAIL mid_next: got valid=%b sb=%0d want 1 1", cmd_if.Cmd_Valid, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      vectors++;
      if ({cmd_if.Cmd_Opcode, cmd_if.Cmd_Len} !== {e.op, e.len}) begin
        miscompares++; $display("FAIL mid_next_hdr: got %h want %h", {cmd_if.Cmd_Opcode, cmd_if.Cmd_Len}, {e.op, e.len});
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_timeout();
    exp_t e;
    int   t0;
    t0 = tmo_n;
    tx_q = '{8'hA5, 8'h10};
    send_q();
`ifdef UART_RX_CMD_TIMEOUT_EN
    for (int c = 0; (c < int'(TMO) + 20) && (tmo_n == t0); c++) begin
      @(negedge clk);
    end
    @(negedge clk);
    vectors++;
    if (tmo_n - t0 != 1) begin
      miscompares++; $display("FAIL tmo_pulse: got %0d pulses want 1", tmo_n - t0);
    end
    tx_q = '{8'hA5, 8'h10};
    send_q();
`else
    repeat (300) @(negedge clk);
    vectors++;
    if (tmo_n != t0) begin
      miscompares++; $display("FAIL tmo_off: got %0d pulses want 0", tmo_n - t0);
    end
`endif
    e = '0; e.op = 8'h10; e.len = 8'd1; e.pld[0] = 8'hAA;
    exp_q.push_back(e);
    tx_q = '{8'h01, 8'hAA, 8'h45};
    send_q();
    vectors++;
    if (exp_q.size() == 0 || cmd_if.Cmd_Valid !== 1'b1) begin
      miscompares++; $display("FAIL tmo_frame: got valid=%b sb=%0d want 1 1", cmd_if.Cmd_Valid, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      vectors++;
      if ({cmd_if.Cmd_Opcode, cmd_if.Cmd_Len} !== {e.op, e.len}) begin
        miscompares++; $display("FAIL tmo_frame_hdr: got %h want %h", {cmd_if.Cmd_Opcode, cmd_if.Cmd_Len}, {e.op, e.len});
      end
      cmd_if.Pld_Raddr = 4'd0; #1;
      vectors++;
      if (cmd_if.Pld_Rdata !== e.pld[0]) begin
        miscompares++; $display("FAIL tmo_frame_pld: got %h want %h", cmd_if.Pld_Rdata, e.pld[0]);
      end
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic_cmd();
    test_config();
    test_bad_checksum();
    test_bad_len();
    test_overrun();
    test_max_len();
    test_reset_mid_frame();
    test_timeout();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++; $display("FAIL sb_drain: got %0d leftover want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
